btn_event: RTL and testbench

- Downstream consumer of the debounced switch level `db` produced by the debounce stage.
- Turns the clean level into registered single-cycle events: press, release, short press, double press and long press.
- Keeps a wrapping press counter.
- Shares the same `clk` and the same slow enable `tick` as the debounce stage. All timing is measured in ticks, not clocks.

---
 rtl/btn_event_if.sv | 25 ++
 rtl/btn_event.sv | 167 ++++++++++++++++
 tb/tb_btn_event.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_event_if.sv
// Button event bundle: tick/db toward the event decoder, registered event pulses back.
// The release event is carried as release_pulse because "release" is a reserved word.
interface btn_event_if #(
    parameter int CW = 8
);
    logic          tick;
    logic          db;
    logic          press;
    logic          release_pulse;
    logic          short_press;
    logic          double_press;
    logic          long_press;
    logic          held;
    logic [CW-1:0] press_count;

    modport master (
        output tick, db,
        input  press, release_pulse, short_press, double_press, long_press, held, press_count
    );

    modport slave (
        input  tick, db,
        output press, release_pulse, short_press, double_press, long_press, held, press_count
    );
endinterface

// File: rtl/btn_event.sv
// Button event decoder: turns the debounced level into registered press/release/short/
// double/long pulses, a held level and a wrapping press counter. Timing counts ticks.
module btn_event #(
    parameter int LONG_TICKS = 50,
    parameter int DBL_TICKS  = 25,
    parameter int TW         = 8,
    parameter int CW         = 8
) (
    input  logic         clk,
    input  logic         rstb,
    btn_event_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IGNORE   = 3'd0,
        S_IDLE     = 3'd1,
        S_PRESSED  = 3'd2,
        S_WAIT2    = 3'd3,
        S_PRESSED2 = 3'd4,
        S_LONG     = 3'd5
    } state_t;

    localparam logic [TW-1:0] LONG_T = TW'(LONG_TICKS);
    localparam logic [TW-1:0] DBL_T  = TW'(DBL_TICKS);

    state_t        state_r;
    state_t        state_next_s;
    logic          db_q_r;
    logic [TW-1:0] tcnt_r;
    logic [TW-1:0] tcnt_next_s;
    logic [TW-1:0] tcnt_inc_s;
    logic          rise_s;
    logic          fall_s;
    logic          press_s;
    logic          release_s;
    logic          short_s;
    logic          double_s;
    logic          long_s;
    logic          count_inc_s;

    assign rise_s     = bus.db & ~db_q_r;
    assign fall_s     = ~bus.db & db_q_r;
    assign tcnt_inc_s = tcnt_r + TW'(1);

    // State, previous-level and tick-counter registers; reset lands in IGNORE if the button is already down.
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_r <= bus.db ? S_IGNORE : S_IDLE;
            db_q_r  <= bus.db;
            tcnt_r  <= {TW{1'b0}};
        end else begin
            state_r <= state_next_s;
            db_q_r  <= bus.db;
            tcnt_r  <= tcnt_next_s;
        end
    end

    // Next-state decision; an edge always wins over a tick arriving in the same cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IGNORE: begin
                if (fall_s) state_next_s = S_IDLE;
                else        state_next_s = S_IGNORE;
            end
            S_IDLE: begin
                if (rise_s) state_next_s = S_PRESSED;
                else        state_next_s = S_IDLE;
            end
            S_PRESSED: begin
                if (fall_s)                                 state_next_s = S_WAIT2;
                else if (bus.tick && (tcnt_inc_s == LONG_T)) state_next_s = S_LONG;
                else                                        state_next_s = S_PRESSED;
            end
            S_WAIT2: begin
                if (rise_s)                                 state_next_s = S_PRESSED2;
                else if (bus.tick && (tcnt_inc_s == DBL_T))  state_next_s = S_IDLE;
                else                                        state_next_s = S_WAIT2;
            end
            S_PRESSED2: begin
                if (fall_s)                                 state_next_s = S_IDLE;
                else if (bus.tick && (tcnt_inc_s == LONG_T)) state_next_s = S_LONG;
                else                                        state_next_s = S_PRESSED2;
            end
            S_LONG: begin
                if (fall_s) state_next_s = S_IDLE;
                else        state_next_s = S_LONG;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Event decisions and tick-counter update for the coming edge.
    always_comb begin
        press_s     = 1'b0;
        release_s   = 1'b0;
        short_s     = 1'b0;
        double_s    = 1'b0;
        long_s      = 1'b0;
        count_inc_s = 1'b0;
        tcnt_next_s = tcnt_r;
        case (state_r)
            S_IDLE: begin
                if (rise_s) begin
                    press_s     = 1'b1;
                    count_inc_s = 1'b1;
                    tcnt_next_s = {TW{1'b0}};
                end else begin
                    tcnt_next_s = tcnt_r;
                end
            end
            S_PRESSED, S_PRESSED2: begin
                if (fall_s) begin
                    release_s   = 1'b1;
                    double_s    = (state_r == S_PRESSED2);
                    tcnt_next_s = {TW{1'b0}};
                end else if (bus.tick) begin
                    tcnt_next_s = tcnt_inc_s;
                    long_s      = (tcnt_inc_s == LONG_T);
                end else begin
                    tcnt_next_s = tcnt_r;
                end
            end
            S_WAIT2: begin
                if (rise_s) begin
                    press_s     = 1'b1;
                    count_inc_s = 1'b1;
                    tcnt_next_s = {TW{1'b0}};
                end else if (bus.tick) begin
                    tcnt_next_s = tcnt_inc_s;
                    short_s     = (tcnt_inc_s == DBL_T);
                end else begin
                    tcnt_next_s = tcnt_r;
                end
            end
            S_LONG: begin
                if (fall_s) begin
                    release_s   = 1'b1;
                    tcnt_next_s = {TW{1'b0}};
                end else begin
                    tcnt_next_s = tcnt_r;
                end
            end
            default: tcnt_next_s = tcnt_r;
        endcase
    end

    // Output registers: one-cycle pulses, held level (masked while ignoring) and press counter.
    always_ff @(posedge clk) begin
        if (rstb) begin
            bus.press         <= 1'b0;
            bus.release_pulse <= 1'b0;
            bus.short_press   <= 1'b0;
            bus.double_press  <= 1'b0;
            bus.long_press    <= 1'b0;
            bus.held          <= 1'b0;
            bus.press_count   <= {CW{1'b0}};
        end else begin
            bus.press         <= press_s;
            bus.release_pulse <= release_s;
            bus.short_press   <= short_s;
            bus.double_press  <= double_s;
            bus.long_press    <= long_s;
            bus.held          <= (state_r == S_IGNORE) ? 1'b0 : db_q_r;
            bus.press_count   <= bus.press_count + {{(CW-1){1'b0}}, count_inc_s};
        end
    end
endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: fixed vector table, random stimulus against a click-level
// reference model, and scenario sequences for the multi-cycle corner cases.
module tb_btn_event;
    localparam int LT = 4;
    localparam int DT = 3;

    logic clk = 1'b0;
    logic rstb = 1'b1;
    always #10 clk = ~clk;

    btn_event_if #(.CW(8)) bif ();
    btn_event #(.LONG_TICKS(LT), .DBL_TICKS(DT), .TW(8), .CW(8)) dut (
        .clk(clk), .rstb(rstb), .bus(bif)
    );

    typedef struct {
        logic       r;
        logic       t;
        logic       d;
        logic [5:0] ev;   // press, release, short, double, long, held
        logic [7:0] cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: button seen as clicks, hold duration and wait-for-second-click window
    logic m_prev = 1'b0;
    logic m_ignore = 1'b0;
    logic m_long_done = 1'b0;
    logic m_second = 1'b0;
    logic m_pending = 1'b0;
    int   m_hold = 0;
    int   m_wait = 0;
    int   m_count = 0;

    int phase = 0;
    int tick_total = 0;
    int press_n, rel_n, short_n, dbl_n, long_n, held_low_n, rel_tick, short_tick;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        press_n = 0; rel_n = 0; short_n = 0; dbl_n = 0; long_n = 0;
        held_low_n = 0; rel_tick = 0; short_tick = 0;
    endtask

    function automatic logic [5:0] act_ev();
        return {bif.press, bif.release_pulse, bif.short_press, bif.double_press,
                bif.long_press, bif.held};
    endfunction

    task automatic step(input logic r, input logic d, input logic t);
        logic [5:0] e;
        logic rise, fall;
        @(negedge clk);
        rstb = r; bif.db = d; bif.tick = t;
        e = 6'b0;
        if (r) begin
            m_prev = d; m_ignore = d; m_pending = 1'b0; m_second = 1'b0;
            m_long_done = 1'b0; m_hold = 0; m_wait = 0; m_count = 0;
        end else begin
            e[0] = m_ignore ? 1'b0 : m_prev;
            rise = d && !m_prev;
            fall = !d && m_prev;
            if (t) tick_total++;
            if (rise) begin
                e[5] = 1'b1;
                m_count = (m_count + 1) % 256;
                m_second = m_pending; m_pending = 1'b0;
                m_hold = 0; m_long_done = 1'b0;
            end else if (fall) begin
                if (m_ignore) m_ignore = 1'b0;
                else begin
                    e[4] = 1'b1;
                    if (!m_long_done && m_second) e[2] = 1'b1;
                    else if (!m_long_done) begin m_pending = 1'b1; m_wait = 0; end
                    m_second = 1'b0;
                end
            end else if (t) begin
                if (m_prev && !m_ignore && !m_long_done) begin
                    m_hold++;
                    if (m_hold == LT) begin e[1] = 1'b1; m_long_done = 1'b1; m_second = 1'b0; end
                end else if (m_pending) begin
                    m_wait++;
                    if (m_wait == DT) begin e[3] = 1'b1; m_pending = 1'b0; end
                end
            end
            m_prev = d;
        end
        @(posedge clk);
        #1;
        check($sformatf("cycle_events@%0t", $time), int'(act_ev()), int'(e));
        check($sformatf("cycle_count@%0t", $time), int'(bif.press_count), m_count);
        if (bif.press) press_n++;
        if (bif.release_pulse) begin rel_n++; rel_tick = tick_total; end
        if (bif.short_press) begin short_n++; short_tick = tick_total; end
        if (bif.double_press) dbl_n++;
        if (bif.long_press) long_n++;
        if (!bif.held) held_low_n++;
    endtask

    task automatic cyc(input logic d);
        logic t;
        t = (phase == 9);
        phase = (phase + 1) % 10;
        step(1'b0, d, t);
    endtask

    task automatic hold(input logic d, input int nticks);
        for (int i = 0; i < nticks * 10; i++) cyc(d);
    endtask

    task automatic do_reset(input logic d);
        step(1'b1, d, 1'b0);
        clear_counts();
    endtask

    vec_t tbl[21];
    logic rd;
    int   k;

    initial begin
        bif.db = 1'b0; bif.tick = 1'b0;
        clear_counts();
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 6'b000000, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 6'b100000, 8'd1};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 6'b000001, 8'd1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 6'b000001, 8'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 6'b010001, 8'd1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 6'b000000, 8'd1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 6'b000000, 8'd1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 6'b001000, 8'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 6'b000000, 8'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 6'b000000, 8'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 6'b000000, 8'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 6'b000000, 8'd0};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 6'b100000, 8'd1};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 6'b000001, 8'd1};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 6'b000001, 8'd1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 6'b000001, 8'd1};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 6'b000001, 8'd1};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 6'b000011, 8'd1};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 6'b000001, 8'd1};
        tbl[19] = '{1'b0, 1'b0, 1'b0, 6'b010001, 8'd1};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 6'b000000, 8'd1};

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].r, tbl[i].d, tbl[i].t);
            check($sformatf("table_ev[%0d]", i), int'(act_ev()), int'(tbl[i].ev));
            check($sformatf("table_cnt[%0d]", i), int'(bif.press_count), int'(tbl[i].cnt));
        end

        // random stimulus against the model
        rd = 1'b0;
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) rd = ~rd;
            step($urandom_range(0, 99) == 0, rd, $urandom_range(0, 3) == 0);
        end

        // 1: single click
        do_reset(1'b0);
        hold(1'b1, 2); hold(1'b0, 5);
        check("click_press", press_n, 1);
        check("click_release", rel_n, 1);
        check("click_short", short_n, 1);
        check("click_short_delay", short_tick - rel_tick, 3);
        check("click_no_dbl_long", dbl_n + long_n, 0);
        check("click_count", int'(bif.press_count), 1);

        // 2: double click
        do_reset(1'b0);
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 5);
        check("dbl_press", press_n, 2);
        check("dbl_release", rel_n, 2);
        check("dbl_double", dbl_n, 1);
        check("dbl_no_short", short_n, 0);
        check("dbl_count", int'(bif.press_count), 2);

        // 3: long press
        do_reset(1'b0);
        hold(1'b1, 1);
        held_low_n = 0;
        hold(1'b1, 9);
        check("long_held", held_low_n, 0);
        check("long_no_early_release", rel_n, 0);
        hold(1'b0, 2);
        check("long_once", long_n, 1);
        check("long_release", rel_n, 1);
        check("long_no_short", short_n, 0);

        // 4: second press goes long
        do_reset(1'b0);
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 6); hold(1'b0, 5);
        check("p2long_long", long_n, 1);
        check("p2long_no_short", short_n, 0);
        check("p2long_no_dbl", dbl_n, 0);
        check("p2long_count", int'(bif.press_count), 2);

        // 5a: db high through reset
        do_reset(1'b1);
        hold(1'b1, 2);
        check("ign_no_press", press_n, 0);
        hold(1'b0, 1);
        check("ign_no_release", rel_n, 0);
        hold(1'b1, 1); hold(1'b0, 5);
        check("ign_press", press_n, 1);
        check("ign_count", int'(bif.press_count), 1);

        // 5b: reset while waiting for a second click
        do_reset(1'b0);
        hold(1'b1, 1);
        cyc(1'b0); cyc(1'b0); cyc(1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("rst_w2_outputs", int'(act_ev()), 0);
        check("rst_w2_count", int'(bif.press_count), 0);
        clear_counts();
        hold(1'b0, 5);
        check("rst_w2_no_short", short_n, 0);

        // 6a: press counter wrap
        do_reset(1'b0);
        for (int i = 0; i < 256; i++) begin
            hold(1'b1, 1); hold(1'b0, 4);
        end
        check("wrap_presses", press_n, 256);
        check("wrap_count", int'(bif.press_count), 0);

        // 6b: second rise coincident with a tick, then fall three ticks later
        do_reset(1'b0);
        hold(1'b1, 1);
        cyc(1'b0);
        while (phase != 9) cyc(1'b0);
        cyc(1'b1);
        k = 0;
        while (k < 3) begin
            if (phase == 9) k++;
            cyc(1'b1);
        end
        hold(1'b0, 5);
        check("prio_press", press_n, 2);
        check("prio_double", dbl_n, 1);
        check("prio_no_short", short_n, 0);
        check("prio_no_long", long_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
